// File: rtl/ihex_uart_loader.sv
// Intel HEX loader over UART: 8N1 receiver, record parser with checksum,
// byte-write port, and a transmitter returning one status string per record.

// Receiver: 2-flop synchronizer, mid-bit sampling, frames with a bad stop bit are discarded.
module uart_rx (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] prescaler,
    input  logic        rx,
    output logic        we_out,
    output logic [7:0]  data_out
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   state, state_nxt;
    logic        sync1, sync2, prev;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        we_nxt;
    logic [7:0]  data_nxt;

    // Synchronize rx and keep the previous level for falling-edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            we_out   <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shift    <= shift_nxt;
            we_out   <= we_nxt;
            data_out <= data_nxt;
        end
    end

    // Next state: start confirmed at T/2, then every sample one full bit later
    always_comb begin
        state_nxt = state;
        cnt_nxt   = 16'(cnt + 16'd1);
        idx_nxt   = idx;
        shift_nxt = shift;
        we_nxt    = 1'b0;
        data_nxt  = data_out;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (prev && !sync2) state_nxt = RX_START;
            end
            RX_START: begin
                if (cnt == {1'b0, prescaler[15:1]}) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == prescaler) begin
                    cnt_nxt   = '0;
                    shift_nxt = {sync2, shift[7:1]};
                    idx_nxt   = 3'(idx + 3'd1);
                    if (idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == prescaler) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    if (sync2) begin
                        we_nxt   = 1'b1;
                        data_nxt = shift;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end
endmodule

// Transmitter: accepts a byte while sendable, frame begins on the following cycle.
module uart_tx (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] prescaler,
    input  logic        sendreq,
    input  logic [7:0]  data_in,
    output logic        sendable,
    output logic        tx
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_nxt;

    // State, datapath and line registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            sendable <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            sendable <= (state_nxt == TX_IDLE);
        end
    end

    // Next state; the line level is derived from where the frame will be next cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = 16'(cnt + 16'd1);
        idx_nxt   = idx;
        shift_nxt = shift;
        tx_nxt    = 1'b1;
        case (state)
            TX_IDLE: begin
                cnt_nxt = '0;
                if (sendreq) begin
                    shift_nxt = data_in;
                    state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (cnt == prescaler) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (cnt == prescaler) begin
                    cnt_nxt   = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    idx_nxt   = 3'(idx + 3'd1);
                    if (idx == 3'd7) state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (cnt == prescaler) begin
                    cnt_nxt   = '0;
                    state_nxt = TX_IDLE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
        case (state_nxt)
            TX_START: tx_nxt = 1'b0;
            TX_DATA:  tx_nxt = shift_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end
endmodule

// Loader top: parser FSM, write port and response sender
module ihex_uart_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] prescaler,
    input  logic        rx,
    output logic        tx,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data
);
    typedef enum logic [2:0] {P_IDLE, P_LEN, P_ADDR, P_TYPE, P_DATA, P_CSUM} p_state_t;
    typedef enum logic [1:0] {R_OK, R_BAD, R_SYNTAX, R_END} resp_t;

    localparam logic [7:0] CH_COLON = 8'h3A;

    logic       rx_we;
    logic [7:0] rx_data;
    logic       sendable;
    logic       sendreq_c;
    logic [7:0] tx_char_c;

    p_state_t    p_state, p_nxt;
    logic [1:0]  dcnt, dcnt_nxt;
    logic [3:0]  hi_nib, hi_nxt;
    logic [7:0]  len, len_nxt;
    logic [15:0] addr, addr_nxt;
    logic [7:0]  rtype, rtype_nxt;
    logic [7:0]  sum, sum_nxt;
    logic [7:0]  idx, idx_nxt;
    logic        we_nxt;
    logic [15:0] maddr_nxt;
    logic [7:0]  mdata_nxt;
    logic        resp_req, req_nxt;
    resp_t       resp_code, code_nxt;

    logic        is_hex_c;
    logic [3:0]  nib_c;
    logic [7:0]  byte_c;

    logic        busy;
    resp_t       msg;
    logic [2:0]  cidx;
    logic [2:0]  last_c;

    uart_rx u_rx (
        .clock     (clock),
        .reset     (reset),
        .prescaler (prescaler),
        .rx        (rx),
        .we_out    (rx_we),
        .data_out  (rx_data)
    );

    uart_tx u_tx (
        .clock     (clock),
        .reset     (reset),
        .prescaler (prescaler),
        .sendreq   (sendreq_c),
        .data_in   (tx_char_c),
        .sendable  (sendable),
        .tx        (tx)
    );

    // Hex digit decode of the received character
    always_comb begin
        is_hex_c = 1'b1;
        nib_c    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)      nib_c = 4'(rx_data - 8'h30);
        else if (rx_data >= 8'h41 && rx_data <= 8'h46) nib_c = 4'(rx_data - 8'h37);
        else if (rx_data >= 8'h61 && rx_data <= 8'h66) nib_c = 4'(rx_data - 8'h57);
        else                                            is_hex_c = 1'b0;
        byte_c = {hi_nib, nib_c};
    end

    // Parser state and field registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            p_state   <= P_IDLE;
            dcnt      <= '0;
            hi_nib    <= '0;
            len       <= '0;
            addr      <= '0;
            rtype     <= '0;
            sum       <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            resp_req  <= 1'b0;
            resp_code <= R_OK;
        end else begin
            p_state   <= p_nxt;
            dcnt      <= dcnt_nxt;
            hi_nib    <= hi_nxt;
            len       <= len_nxt;
            addr      <= addr_nxt;
            rtype     <= rtype_nxt;
            sum       <= sum_nxt;
            idx       <= idx_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= maddr_nxt;
            mem_data  <= mdata_nxt;
            resp_req  <= req_nxt;
            resp_code <= code_nxt;
        end
    end

    // Parser next state: one step per received character
    always_comb begin
        p_nxt     = p_state;
        dcnt_nxt  = dcnt;
        hi_nxt    = hi_nib;
        len_nxt   = len;
        addr_nxt  = addr;
        rtype_nxt = rtype;
        sum_nxt   = sum;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        maddr_nxt = mem_addr;
        mdata_nxt = mem_data;
        req_nxt   = 1'b0;
        code_nxt  = resp_code;
        if (rx_we) begin
            if (p_state == P_IDLE) begin
                if (rx_data == CH_COLON) begin
                    p_nxt    = P_LEN;
                    dcnt_nxt = '0;
                    sum_nxt  = '0;
                end
            end else if (!is_hex_c) begin
                // Syntax error; a colon also opens the next record
                req_nxt  = 1'b1;
                code_nxt = R_SYNTAX;
                dcnt_nxt = '0;
                sum_nxt  = '0;
                p_nxt    = (rx_data == CH_COLON) ? P_LEN : P_IDLE;
            end else begin
                hi_nxt   = nib_c;
                dcnt_nxt = 2'(dcnt + 2'd1);
                case (p_state)
                    P_LEN: begin
                        if (dcnt[0]) begin
                            len_nxt  = byte_c;
                            sum_nxt  = 8'(sum + byte_c);
                            dcnt_nxt = '0;
                            p_nxt    = P_ADDR;
                        end
                    end
                    P_ADDR: begin
                        addr_nxt = {addr[11:0], nib_c};
                        if (dcnt == 2'd3) begin
                            sum_nxt  = 8'(sum + addr[11:4] + {addr[3:0], nib_c});
                            dcnt_nxt = '0;
                            p_nxt    = P_TYPE;
                        end
                    end
                    P_TYPE: begin
                        if (dcnt[0]) begin
                            rtype_nxt = byte_c;
                            sum_nxt   = 8'(sum + byte_c);
                            dcnt_nxt  = '0;
                            idx_nxt   = '0;
                            p_nxt     = (len == 8'd0) ? P_CSUM : P_DATA;
                        end
                    end
                    P_DATA: begin
                        if (dcnt[0]) begin
                            sum_nxt  = 8'(sum + byte_c);
                            dcnt_nxt = '0;
                            if (rtype == 8'h00) begin
                                we_nxt    = 1'b1;
                                maddr_nxt = 16'(addr + {8'h00, idx});
                                mdata_nxt = byte_c;
                            end
                            idx_nxt = 8'(idx + 8'd1);
                            if (idx == 8'(len - 8'd1)) p_nxt = P_CSUM;
                        end
                    end
                    P_CSUM: begin
                        if (dcnt[0]) begin
                            dcnt_nxt = '0;
                            req_nxt  = 1'b1;
                            p_nxt    = P_IDLE;
                            if (rtype > 8'h05 || 8'(sum + byte_c) != 8'h00) code_nxt = R_BAD;
                            else if (rtype == 8'h01)                         code_nxt = R_END;
                            else                                             code_nxt = R_OK;
                        end
                    end
                    default: p_nxt = P_IDLE;
                endcase
            end
        end
    end

    // Character of the active response at position cidx
    always_comb begin
        last_c    = (msg == R_END) ? 3'd6 : 3'd0;
        sendreq_c = busy && sendable;
        case (msg)
            R_OK:     tx_char_c = 8'h2E;
            R_BAD:    tx_char_c = 8'h58;
            R_SYNTAX: tx_char_c = 8'h3F;
            default: begin
                case (cidx)
                    3'd0:    tx_char_c = 8'h0D;
                    3'd1:    tx_char_c = 8'h0A;
                    3'd2:    tx_char_c = 8'h45;
                    3'd3:    tx_char_c = 8'h4E;
                    3'd4:    tx_char_c = 8'h44;
                    3'd5:    tx_char_c = 8'h0D;
                    default: tx_char_c = 8'h0A;
                endcase
            end
        endcase
    end

    // Response sender: new requests are dropped while a response is in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy <= 1'b0;
            msg  <= R_OK;
            cidx <= '0;
        end else if (busy) begin
            if (sendreq_c) begin
                if (cidx == last_c) busy <= 1'b0;
                else                cidx <= 3'(cidx + 3'd1);
            end
        end else if (resp_req) begin
            busy <= 1'b1;
            msg  <= resp_code;
            cidx <= '0;
        end
    end
endmodule

// File: tb/tb_ihex_uart_loader.sv
// Bench for ihex_uart_loader: record-level model feeds expected writes and tx chars.
module tb_ihex_uart_loader;
    localparam int unsigned BIT_CLKS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] prescaler = 16'd3;
    logic        rx = 1'b1;
    logic        tx;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [23:0] exp_wr[$];
    byte         exp_tx[$];
    string       got_tx = "";
    int          wr_seen = 0;
    logic        we_prev = 1'b0;

    always #5 clock = ~clock;

    ihex_uart_loader dut (
        .clock     (clock),
        .reset     (reset),
        .prescaler (prescaler),
        .rx        (rx),
        .tx        (tx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    function automatic string hexstr(input string s);
        string r = "";
        for (int k = 0; k < s.len(); k++) r = $sformatf("%s%02h", r, s[k]);
        return r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got '%s' expected '%s' (hex)", name, hexstr(got), hexstr(exp));
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    function automatic bit hex_val(input byte c, output logic [3:0] v);
        v = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin v = 4'(c - 8'h30); return 1'b1; end
        if (c >= 8'h41 && c <= 8'h46) begin v = 4'(c - 8'h37); return 1'b1; end
        if (c >= 8'h61 && c <= 8'h66) begin v = 4'(c - 8'h57); return 1'b1; end
        return 1'b0;
    endfunction

    // Record-level model: decode hex pairs, queue writes and responses
    task automatic model_stream(input string s, output string resp, output int nwr);
        int          i;
        int          ndig;
        int          need;
        bit          done;
        logic [3:0]  hi;
        logic [3:0]  nib;
        logic [7:0]  b[$];
        logic [7:0]  total;
        resp = "";
        nwr  = 0;
        i    = 0;
        hi   = 4'h0;
        while (i < s.len()) begin
            if (s[i] != 8'h3A) begin
                i++;
                continue;
            end
            i++;
            b.delete();
            ndig = 0;
            need = 2;
            done = 1'b0;
            while (!done && i < s.len()) begin
                if (!hex_val(s[i], nib)) begin
                    resp = {resp, "?"};
                    if (s[i] != 8'h3A) i++;
                    done = 1'b1;
                end else begin
                    i++;
                    if (ndig % 2 == 0) hi = nib;
                    else begin
                        b.push_back({hi, nib});
                        if (b.size() == 1) need = 2 * (5 + int'(b[0]));
                        if (b.size() >= 5 && b.size() <= 4 + int'(b[0]) && b[3] == 8'h00) begin
                            exp_wr.push_back({16'({b[1], b[2]} + 16'(b.size() - 5)), hi, nib});
                            nwr++;
                        end
                    end
                    ndig++;
                    if (ndig == need) begin
                        total = 8'h00;
                        foreach (b[k]) total = 8'(total + b[k]);
                        if (b[3] > 8'h05 || total != 8'h00) resp = {resp, "X"};
                        else if (b[3] == 8'h01)            resp = {resp, "\015\012END\015\012"};
                        else                                resp = {resp, "."};
                        done = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < resp.len(); k++) exp_tx.push_back(resp[k]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (BIT_CLKS) @(negedge clock);
        end
        rx = good_stop;
        repeat (BIT_CLKS) @(negedge clock);
        rx = 1'b1;
        if (!good_stop) repeat (2 * BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send_byte(s[k], 1'b1);
    endtask

    task automatic expect_vector(input string name, input string s, input string resp_lit, input int wr_lit);
        string mresp;
        int    mwr;
        model_stream(s, mresp, mwr);
        check_str({name, "_model_resp"}, mresp, resp_lit);
        check({name, "_model_writes"}, mwr, wr_lit);
        got_tx  = "";
        wr_seen = 0;
    endtask

    task automatic finish_vector(input string name, input string resp_lit, input int wr_lit);
        for (int k = 0; k < 3000 && exp_tx.size() != 0; k++) @(negedge clock);
        if (exp_tx.size() != 0) fail({name, "_tx_timeout"}, $sformatf("%0d chars not received", exp_tx.size()));
        exp_tx.delete();
        repeat (60) @(negedge clock);
        check_str({name, "_tx"}, got_tx, resp_lit);
        check({name, "_writes"}, wr_seen, wr_lit);
        check({name, "_wr_left"}, exp_wr.size(), 0);
        exp_wr.delete();
    endtask

    task automatic run_vector(input string name, input string s, input string resp_lit, input int wr_lit);
        expect_vector(name, s, resp_lit, wr_lit);
        send_str(s);
        finish_vector(name, resp_lit, wr_lit);
    endtask

    // Write port compare against the model queue
    always @(negedge clock) begin
        if (reset && mem_we) begin
            wr_seen++;
            if (we_prev) fail("we_pulse", "mem_we high on consecutive cycles");
            if (exp_wr.size() == 0) begin
                fail("unexpected_write", $sformatf("addr %04h data %02h", mem_addr, mem_data));
            end else begin
                logic [23:0] e;
                e = exp_wr.pop_front();
                check("write_addr", int'(mem_addr), int'(e[23:8]));
                check("write_data", int'(mem_data), int'(e[7:0]));
            end
        end
        we_prev <= mem_we;
    end

    // Serial decode of tx and compare against expected characters
    initial begin : tx_mon
        logic [7:0] c;
        forever begin
            @(negedge clock);
            if (reset && tx == 1'b0) begin
                repeat (6) @(negedge clock);
                c[0] = tx;
                for (int k = 1; k < 8; k++) begin
                    repeat (BIT_CLKS) @(negedge clock);
                    c[k] = tx;
                end
                repeat (BIT_CLKS) @(negedge clock);
                check("tx_stop", int'(tx), 1);
                got_tx = $sformatf("%s%c", got_tx, c);
                if (exp_tx.size() == 0) fail("unexpected_tx", $sformatf("char %02h", c));
                else check("tx_char", int'(c), int'(exp_tx.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("reset_tx", int'(tx), 1);
        check("reset_we", int'(mem_we), 0);
        check("reset_addr", int'(mem_addr), 0);
        check("reset_data", int'(mem_data), 0);
        reset = 1'b1;
        repeat (100) @(negedge clock);
        check("idle_tx", int'(tx), 1);

        run_vector("single",  ":0100000041BE\015\012", ".", 1);
        run_vector("two",     ":02001000AABB89", ".", 2);
        run_vector("wrap",    ":02FFFF001122CD", ".", 2);
        run_vector("badsum",  ":0100000041BF", "X", 1);
        run_vector("syntax",  ":01G0", "?", 0);
        run_vector("eof",     ":00000001FF", "\015\012END\015\012", 0);
        run_vector("type02",  ":020000021000EC", ".", 0);
        run_vector("type06",  ":00000006FA", "X", 0);
        run_vector("lower",   ":02001000aabb89", ".", 2);
        run_vector("restart", ":01:00000001FF", "?\015\012END\015\012", 0);
        run_vector("crdata",  ":0300200011\015", "?", 1);

        // Frame with a zero stop bit must vanish without disturbing the record
        expect_vector("badstop", ":0100000041BE", ".", 1);
        send_str(":01000");
        send_byte(8'h5A, 1'b0);
        send_str("00041BE");
        finish_vector("badstop", ".", 1);

        // Reset in the middle of a record discards it
        send_str(":0100");
        repeat (10) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset_tx", int'(tx), 1);
        check("midreset_addr", int'(mem_addr), 0);
        check("midreset_data", int'(mem_data), 0);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        run_vector("after_reset", ":0100000041BE", ".", 1);

        repeat (100) @(negedge clock);
        check("final_idle_tx", int'(tx), 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
